// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//
// Shares the single data-memory port between the CPU pipeline and a
// secondary requester (DMA / debug loader). The CPU normally has priority.
// A small starvation counter forces the DMA ahead after STARVE_MAX
// consecutive CPU wins while the DMA is waiting. The winning command is
// registered toward memory. Outstanding reads are tagged by owner so that
// read data is steered back to the requester that issued the read.
//
// Parameters
//   MEM_LAT     cycles from command on mem_*_o to valid mem_rdata_i (1..4)
//   STARVE_MAX  CPU wins with the DMA waiting before the DMA is forced (1..15)
//
// Ports
//   clk_i, rst_i                    clock, synchronous active-high reset
//   cpu_req_i/we_i/addr_i/wdata_i/mask_i   CPU command fields
//   cpu_gnt_o, cpu_stall_o          CPU accepted / CPU must hold
//   cpu_rvalid_o, cpu_rdata_o       CPU read response
//   dma_req_i/we_i/addr_i/wdata_i/mask_i   DMA command fields
//   dma_gnt_o                       DMA accepted
//   dma_rvalid_o, dma_rdata_o       DMA read response
//   mem_re_o, mem_we_o              registered memory strobes
//   mem_addr_o, mem_wdata_o, mem_mask_o    registered command fields
//   mem_rdata_i                     memory read data
module dmem_arbiter #(
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        cpu_req_i,
    input  logic        cpu_we_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [31:0] cpu_wdata_i,
    input  logic [3:0]  cpu_mask_i,
    output logic        cpu_gnt_o,
    output logic        cpu_stall_o,
    output logic        cpu_rvalid_o,
    output logic [31:0] cpu_rdata_o,

    input  logic        dma_req_i,
    input  logic        dma_we_i,
    input  logic [31:0] dma_addr_i,
    input  logic [31:0] dma_wdata_i,
    input  logic [3:0]  dma_mask_i,
    output logic        dma_gnt_o,
    output logic        dma_rvalid_o,
    output logic [31:0] dma_rdata_o,

    output logic        mem_re_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_mask_o,
    input  logic [31:0] mem_rdata_i
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0]       starve_cnt;
    logic             starve_hit;
    logic             dma_win;
    logic             rd_new;
    logic [MEM_LAT:0] tag_v;
    logic [MEM_LAT:0] tag_dma;

    // Grants are combinational; reset suppresses both so memory sees no
    // command in the cycle after reset.
    always_comb begin
        starve_hit = (starve_cnt == STARVE_LIM);
        dma_win    = dma_req_i & (~cpu_req_i | starve_hit);
        cpu_gnt_o  = 1'b0;
        dma_gnt_o  = 1'b0;
        if (!rst_i) begin
            dma_gnt_o = dma_win;
            cpu_gnt_o = cpu_req_i & ~dma_win;
        end
        cpu_stall_o = cpu_req_i & ~cpu_gnt_o;
        rd_new      = (cpu_gnt_o & ~cpu_we_i) | (dma_gnt_o & ~dma_we_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            starve_cnt <= '0;
        end else if (!dma_req_i || dma_gnt_o) begin
            starve_cnt <= '0;
        end else if (cpu_gnt_o && !starve_hit) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    // Command register toward memory. Without a grant only the strobes drop;
    // address, data and mask keep their last values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_re_o    <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            mem_mask_o  <= '0;
        end else if (cpu_gnt_o) begin
            mem_re_o    <= ~cpu_we_i;
            mem_we_o    <= cpu_we_i;
            mem_addr_o  <= cpu_addr_i;
            mem_wdata_o <= cpu_wdata_i;
            mem_mask_o  <= cpu_mask_i;
        end else if (dma_gnt_o) begin
            mem_re_o    <= ~dma_we_i;
            mem_we_o    <= dma_we_i;
            mem_addr_o  <= dma_addr_i;
            mem_wdata_o <= dma_wdata_i;
            mem_mask_o  <= dma_mask_i;
        end else begin
            mem_re_o    <= 1'b0;
            mem_we_o    <= 1'b0;
        end
    end

    // Read tags: index 0 holds the read issued to memory this cycle, so the
    // tail at index MEM_LAT lines up with mem_rdata_i.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tag_v   <= '0;
            tag_dma <= '0;
        end else begin
            tag_v   <= {tag_v[MEM_LAT-1:0], rd_new};
            tag_dma <= {tag_dma[MEM_LAT-1:0], dma_gnt_o};
        end
    end

    // Responses are masked during reset so a read in flight never completes.
    always_comb begin
        cpu_rvalid_o = tag_v[MEM_LAT] & ~tag_dma[MEM_LAT] & ~rst_i;
        dma_rvalid_o = tag_v[MEM_LAT] & tag_dma[MEM_LAT] & ~rst_i;
        cpu_rdata_o  = cpu_rvalid_o ? mem_rdata_i : '0;
        dma_rdata_o  = dma_rvalid_o ? mem_rdata_i : '0;
    end

endmodule
